// File: rtl/voice_allocator.sv
// Four-voice note allocator: retriggers matching notes, fills the lowest free voice,
// otherwise steals the oldest voice tracked by a 2-bit age permutation.
module voice_allocator (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [6:0] note_num,
  input  logic [6:0] note_vel,
  input  logic       note_on,
  input  logic       note_off,
  output logic [6:0] note_num_0,
  output logic [6:0] note_num_1,
  output logic [6:0] note_num_2,
  output logic [6:0] note_num_3,
  output logic [6:0] note_vel_0,
  output logic [6:0] note_vel_1,
  output logic [6:0] note_vel_2,
  output logic [6:0] note_vel_3,
  output logic [3:0] gate,
  output logic [3:0] trig,
  output logic       steal
);

  logic [6:0] r_num [4];
  logic [6:0] r_vel [4];
  logic [1:0] r_age [4];
  logic [3:0] r_gate;
  logic [3:0] r_trig;
  logic       r_steal;

  logic [6:0] w_num_n [4];
  logic [6:0] w_vel_n [4];
  logic [1:0] w_age_n [4];
  logic [3:0] w_gate_n;
  logic [3:0] w_trig_n;
  logic       w_steal_n;

  logic [3:0] w_match;
  logic [3:0] w_oldest;
  logic [1:0] w_hit_idx;
  logic [1:0] w_free_idx;
  logic [1:0] w_old_idx;
  logic [1:0] w_tgt;
  logic       w_is_on;
  logic       w_is_off;

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] idx;
    casez (v)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Match/free/oldest search over the current voice state
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_match[i]  = r_gate[i] && (r_num[i] == note_num);
      w_oldest[i] = (r_age[i] == 2'd3);
    end
    w_hit_idx  = lowest_idx(w_match);
    w_free_idx = lowest_idx(~r_gate);
    w_old_idx  = lowest_idx(w_oldest);
    // A zero-velocity note_on is a note_off; note_on wins over a simultaneous note_off
    w_is_on    = note_on && (note_vel != 7'd0);
    w_is_off   = note_on ? (note_vel == 7'd0) : note_off;
  end

  // Next voice state for the sampled event
  always_comb begin
    w_num_n   = r_num;
    w_vel_n   = r_vel;
    w_age_n   = r_age;
    w_gate_n  = r_gate;
    w_trig_n  = 4'b0000;
    w_steal_n = 1'b0;
    w_tgt     = 2'd0;
    if (w_is_on) begin
      if (|w_match) begin
        w_tgt = w_hit_idx;
      end else if (!(&r_gate)) begin
        w_tgt = w_free_idx;
      end else begin
        w_tgt     = w_old_idx;
        w_steal_n = 1'b1;
      end
      w_num_n[w_tgt]  = note_num;
      w_vel_n[w_tgt]  = note_vel;
      w_gate_n[w_tgt] = 1'b1;
      w_trig_n[w_tgt] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (2'(i) == w_tgt) begin
          w_age_n[i] = 2'd0;
        end else if (r_age[i] < r_age[w_tgt]) begin
          w_age_n[i] = r_age[i] + 2'd1;
        end else begin
          w_age_n[i] = r_age[i];
        end
      end
    end else if (w_is_off && (|w_match)) begin
      w_gate_n[w_hit_idx] = 1'b0;
      w_vel_n[w_hit_idx]  = 7'd0;
    end else begin
      w_tgt = 2'd0;
    end
  end

  // State registers, updated only on enabled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_num[i] <= 7'd0;
        r_vel[i] <= 7'd0;
        r_age[i] <= 2'(3 - i);
      end
      r_gate  <= 4'b0000;
      r_trig  <= 4'b0000;
      r_steal <= 1'b0;
    end else if (ce) begin
      r_num   <= w_num_n;
      r_vel   <= w_vel_n;
      r_age   <= w_age_n;
      r_gate  <= w_gate_n;
      r_trig  <= w_trig_n;
      r_steal <= w_steal_n;
    end
  end

  assign note_num_0 = r_num[0];
  assign note_num_1 = r_num[1];
  assign note_num_2 = r_num[2];
  assign note_num_3 = r_num[3];
  assign note_vel_0 = r_vel[0];
  assign note_vel_1 = r_vel[1];
  assign note_vel_2 = r_vel[2];
  assign note_vel_3 = r_vel[3];
  assign gate       = r_gate;
  assign trig       = r_trig;
  assign steal      = r_steal;

endmodule

// File: tb/tb_voice_allocator.sv
// Table-driven check of voice_allocator plus an asynchronous reset sequence.
module tb_voice_allocator;

  logic       clk = 1'b0;
  logic       rst, ce, note_on, note_off;
  logic [6:0] note_num, note_vel;
  logic [6:0] note_num_0, note_num_1, note_num_2, note_num_3;
  logic [6:0] note_vel_0, note_vel_1, note_vel_2, note_vel_3;
  logic [3:0] gate, trig;
  logic       steal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  voice_allocator dut (
    .clk(clk), .rst(rst), .ce(ce),
    .note_num(note_num), .note_vel(note_vel),
    .note_on(note_on), .note_off(note_off),
    .note_num_0(note_num_0), .note_num_1(note_num_1),
    .note_num_2(note_num_2), .note_num_3(note_num_3),
    .note_vel_0(note_vel_0), .note_vel_1(note_vel_1),
    .note_vel_2(note_vel_2), .note_vel_3(note_vel_3),
    .gate(gate), .trig(trig), .steal(steal)
  );

  typedef struct {
    logic        rst, ce, on, off;
    logic [6:0]  num, vel;
    logic [27:0] e_num;   // {voice3, voice2, voice1, voice0}
    logic [27:0] e_vel;
    logic [3:0]  e_gate, e_trig;
    logic        e_steal;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic r, c, on, off, input int num, vel,
                              input int n3, n2, n1, n0, v3, v2, v1, v0,
                              input logic [3:0] g, t, input logic s);
    vec_t v;
    v.rst = r; v.ce = c; v.on = on; v.off = off;
    v.num = 7'(num); v.vel = 7'(vel);
    v.e_num = {7'(n3), 7'(n2), 7'(n1), 7'(n0)};
    v.e_vel = {7'(v3), 7'(v2), 7'(v1), 7'(v0)};
    v.e_gate = g; v.e_trig = t; v.e_steal = s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " num"}, {4'h0, note_num_3, note_num_2, note_num_1, note_num_0}, {4'h0, v.e_num});
    chk({tag, " vel"}, {4'h0, note_vel_3, note_vel_2, note_vel_1, note_vel_0}, {4'h0, v.e_vel});
    chk({tag, " gate"}, {28'h0, gate}, {28'h0, v.e_gate});
    chk({tag, " trig"}, {28'h0, trig}, {28'h0, v.e_trig});
    chk({tag, " steal"}, {31'h0, steal}, {31'h0, v.e_steal});
  endtask

  initial begin
    //            rst ce on off num vel   n3 n2 n1 n0     v3  v2  v1  v0     gate     trig     steal
    tbl[0]  = mk(1, 1, 0, 0,  0,   0,   0, 0, 0, 0,     0,  0,  0,  0,  4'b0000, 4'b0000, 0);
    tbl[1]  = mk(0, 1, 1, 0, 10, 127,   0, 0, 0,10,     0,  0,  0,127,  4'b0001, 4'b0001, 0);
    tbl[2]  = mk(0, 1, 1, 0, 11, 127,   0, 0,11,10,     0,  0,127,127,  4'b0011, 4'b0010, 0);
    tbl[3]  = mk(0, 1, 1, 0, 12, 127,   0,12,11,10,     0,127,127,127,  4'b0111, 4'b0100, 0);
    tbl[4]  = mk(0, 1, 1, 0, 13, 127,  13,12,11,10,   127,127,127,127,  4'b1111, 4'b1000, 0);
    tbl[5]  = mk(0, 1, 0, 0,  0,   0,  13,12,11,10,   127,127,127,127,  4'b1111, 4'b0000, 0);
    tbl[6]  = mk(0, 1, 1, 0, 15, 100,  13,12,11,15,   127,127,127,100,  4'b1111, 4'b0001, 1);
    tbl[7]  = mk(0, 1, 0, 0,  0,   0,  13,12,11,15,   127,127,127,100,  4'b1111, 4'b0000, 0);
    tbl[8]  = mk(0, 1, 0, 1, 11,   0,  13,12,11,15,   127,127,  0,100,  4'b1101, 4'b0000, 0);
    tbl[9]  = mk(0, 1, 1, 0, 14,  90,  13,12,14,15,   127,127, 90,100,  4'b1111, 4'b0010, 0);
    tbl[10] = mk(0, 1, 1, 0, 14,  50,  13,12,14,15,   127,127, 50,100,  4'b1111, 4'b0010, 0);
    tbl[11] = mk(0, 1, 1, 0, 16,  70,  13,16,14,15,   127, 70, 50,100,  4'b1111, 4'b0100, 1);
    tbl[12] = mk(0, 1, 1, 0, 17,   0,  13,16,14,15,   127, 70, 50,100,  4'b1111, 4'b0000, 0);
    tbl[13] = mk(0, 1, 1, 0, 16,   0,  13,16,14,15,   127,  0, 50,100,  4'b1011, 4'b0000, 0);
    tbl[14] = mk(0, 1, 0, 1, 99,   0,  13,16,14,15,   127,  0, 50,100,  4'b1011, 4'b0000, 0);
    tbl[15] = mk(0, 0, 1, 0, 40,  40,  13,16,14,15,   127,  0, 50,100,  4'b1011, 4'b0000, 0);
    tbl[16] = mk(0, 1, 1, 1, 30,  60,  13,30,14,15,   127, 60, 50,100,  4'b1111, 4'b0100, 0);
    tbl[17] = mk(0, 1, 1, 0, 20,  64,  20,30,14,15,    64, 60, 50,100,  4'b1111, 4'b1000, 1);
    tbl[18] = mk(0, 1, 1, 0, 20, 100,  20,30,14,15,   100, 60, 50,100,  4'b1111, 4'b1000, 0);
    tbl[19] = mk(0, 0, 0, 0,  0,   0,  20,30,14,15,   100, 60, 50,100,  4'b1111, 4'b1000, 0);
    tbl[20] = mk(0, 1, 1, 0, 20,   0,  20,30,14,15,     0, 60, 50,100,  4'b0111, 4'b0000, 0);
    tbl[21] = mk(0, 1, 0, 0,  0,   0,  20,30,14,15,     0, 60, 50,100,  4'b0111, 4'b0000, 0);

    rst = 1'b1; ce = 1'b0; note_on = 1'b0; note_off = 1'b0;
    note_num = 7'd0; note_vel = 7'd0;

    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      rst = tbl[k].rst; ce = tbl[k].ce; note_on = tbl[k].on; note_off = tbl[k].off;
      note_num = tbl[k].num; note_vel = tbl[k].vel;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", k), tbl[k]);
    end

    // Asynchronous reset between edges, discarding the event in flight
    @(negedge clk);
    ce = 1'b1; note_on = 1'b1; note_off = 1'b0; note_num = 7'd50; note_vel = 7'd50;
    rst = 1'b1;
    #1;
    chk_all("async_rst", mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0));
    #1;
    rst = 1'b0; note_num = 7'd5; note_vel = 7'd5;
    @(posedge clk);
    #1;
    chk_all("post_rst", mk(0, 1, 1, 0, 5, 5, 0, 0, 0, 5, 0, 0, 0, 5, 4'b0001, 4'b0001, 0));
    @(negedge clk);
    note_on = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst_idle", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 5, 4'b0001, 4'b0000, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter: none; voice count fixed at 4.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ce  input  1  clock enable; state and outputs hold when 0.
REQ-005 note_num  input  7  note number for the current event.
REQ-006 note_vel  input  7  velocity for the current event.
REQ-007 note_on  input  1  one-cycle note-on event strobe.
REQ-008 note_off  input  1  one-cycle note-off event strobe.
REQ-009 note_num_0..note_num_3  output  7 each  note number assigned to voice 0..3.
REQ-010 note_vel_0..note_vel_3  output  7 each  velocity of voice 0..3; 0 = silent.
REQ-011 gate  output  4  bit v = voice v held.
REQ-012 trig  output  4  bit v = one-cycle pulse when voice v is (re)started.
REQ-013 steal  output  1  one-cycle pulse when an active voice is stolen.

Function
REQ-014 All outputs SHALL be registered; response appears on the first rising edge with ce=1 after the event is sampled (latency 1 cycle).
REQ-015 Events SHALL be sampled only on cycles with ce=1; strobes on ce=0 cycles are lost.
REQ-016 note_on with note_vel=0 SHALL be handled exactly as note_off for that note_num.
REQ-017 Each voice SHALL hold a 2-bit age; the four ages SHALL always form a permutation of 0..3 (0 = most recently started, 3 = oldest).
REQ-018 Touching voice v: every voice with age < age[v] increments by 1; age[v] becomes 0; other ages unchanged.
REQ-019 note_on, note_num matching a voice with gate=1 SHALL retrigger that voice: note_vel updated, trig[v] pulse, voice touched, no other voice changed.
REQ-020 note_on, no match, any gate bit 0: SHALL take the lowest-index free voice: load note_num/note_vel, set gate[v], pulse trig[v], touch v.
REQ-021 note_on, no match, all gates 1: SHALL steal the voice with age 3: load note_num/note_vel, keep gate[v]=1, pulse trig[v] and steal, touch v.
REQ-022 note_off matching a voice with gate=1 SHALL clear gate[v] and set note_vel_v to 0; note_num_v retained; ages unchanged.
REQ-023 note_off with no matching active voice SHALL be ignored (no output change).
REQ-024 note_on and note_off asserted in the same sampled cycle: note_on SHALL be processed; note_off ignored.
REQ-025 Match search SHALL compare only voices with gate=1; if more than one matches (not reachable in normal operation), the lowest index SHALL be used.
REQ-026 trig and steal SHALL be 0 on every cycle without an accepted note_on; at most one trig bit high per cycle.
REQ-027 Free-voice choice SHALL ignore ages; steal choice SHALL ignore index.

Reset
REQ-028 While rst=1: all note_num_v=0, note_vel_v=0, gate=4'b0000, trig=4'b0000, steal=0.
REQ-029 While rst=1: ages voice0..3 = 3,2,1,0.
REQ-030 Reset asserted mid-operation SHALL take effect immediately, independent of clk and ce; the event in flight is discarded.
REQ-031 First event after rst deasserts SHALL be processed per REQ-014 with no extra delay.

Verification
REQ-032 Reset, then note_on 10/127, 11/127, 12/127, 13/127 -> voices 0..3 hold 10,11,12,13; gate=1111; trig pulses 0001,0010,0100,1000; steal never 1.
REQ-033 From REQ-032 state, note_on 15/100 -> voice 0 (oldest) gets 15/100; trig=0001; steal=1 for one cycle; gate=1111.
REQ-034 From REQ-032 state, note_off 11 -> gate=1101, note_vel_1=0, note_num_1=11; then note_on 14/90 -> voice 1 gets 14/90, trig=0010, steal=0.
REQ-035 Note_on 20/64, then note_on 20/100 -> same voice retriggered, vel 100, second trig pulse, no other voice allocated; note_on 20/0 -> that gate clears.
REQ-036 Note_on and note_off for note 30 in the same cycle -> note 30 allocated, gate set; note_off 99 with no match -> all outputs unchanged.
REQ-037 ce=0 with note_on strobed -> no output change; rst pulse between clock edges with voices active -> all outputs cleared immediately.
